// File: rtl/jtag_scan_master_if.sv
// Request/response bus of the JTAG scan master.
// The slave modport is the scan engine, the master modport is whoever issues scans.
interface jtag_scan_master_if #(
  parameter int MaxLen = 64
);
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic                      req_reset_i;
  logic                      req_ir_i;
  logic [$clog2(MaxLen)-1:0] req_len_i;
  logic [MaxLen-1:0]         req_data_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [MaxLen-1:0]         rsp_data_o;

  modport slave (
    input  req_valid_i, req_reset_i, req_ir_i, req_len_i, req_data_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o
  );

  modport master (
    output req_valid_i, req_reset_i, req_ir_i, req_len_i, req_data_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o
  );
endinterface

// File: rtl/jtag_scan_master.sv
// JTAG initiator: turns one IR/DR scan or TAP reset request into a complete
// TCK/TMS/TDI sequence that starts and ends in Run-Test/Idle, and returns
// the TDO bits captured during the shift.
// Every TCK period ("tick") is 2*ClkDiv clock cycles: TMS/TDI change on the
// edge that drives TCK low, TDO is sampled on the edge that drives TCK high.
module jtag_scan_master #(
  parameter int ClkDiv = 4,
  parameter int MaxLen = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  jtag_scan_master_if.slave         bus,
  output logic                      jtag_tck_o,
  output logic                      jtag_tms_o,
  output logic                      jtag_tdi_o,
  output logic                      jtag_trst_no,
  input  logic                      jtag_tdo_i
);

  localparam int LenW = $clog2(MaxLen);
  localparam int PhW  = $clog2(2 * ClkDiv);

  // Phase counter values of the cycle before TCK rises and before the tick ends
  localparam logic [PhW-1:0] RiseAt = PhW'(ClkDiv - 1);
  localparam logic [PhW-1:0] FallAt = PhW'(2 * ClkDiv - 1);

  localparam logic [2:0] ST_RSTSEQ = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_PRE    = 3'd2;
  localparam logic [2:0] ST_SHIFT  = 3'd3;
  localparam logic [2:0] ST_POST   = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  logic [2:0]        r_state;
  logic [PhW-1:0]    r_phase;
  logic [LenW-1:0]   r_tickIdx;
  logic              r_tck;
  logic              r_tms;
  logic              r_tdi;
  logic              r_trstn;
  logic              r_isIr;
  logic              r_isReset;
  logic [LenW-1:0]   r_len;
  logic [MaxLen-1:0] r_data;
  logic [MaxLen-1:0] r_rspData;

  logic              w_accept;
  logic              w_rise;
  logic              w_tickEnd;
  logic              w_preLast;
  logic [LenW-1:0]   w_idxNext;

  assign w_accept  = (r_state == ST_IDLE) && bus.req_valid_i;
  assign w_rise    = (r_phase == RiseAt);
  assign w_tickEnd = (r_phase == FallAt);
  assign w_idxNext = r_tickIdx + LenW'(1);
  // IR scans need one extra Select-IR tick before Capture/Shift
  assign w_preLast = r_isIr ? (r_tickIdx == LenW'(3)) : (r_tickIdx == LenW'(2));

  // Tick sequencer: state, TCK phase and the TMS/TDI value of each tick
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_RSTSEQ;
      r_phase   <= '0;
      r_tickIdx <= '0;
      r_tck     <= 1'b0;
      r_tms     <= 1'b1;
      r_tdi     <= 1'b0;
      r_trstn   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tck <= 1'b0;
          r_tms <= 1'b0;
          r_tdi <= 1'b0;
          if (w_accept) begin
            r_phase   <= '0;
            r_tickIdx <= '0;
            r_tms     <= 1'b1;
            r_state   <= bus.req_reset_i ? ST_RSTSEQ : ST_PRE;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          if (!r_trstn) begin
            // First edge out of reset: release TRSTn and start tick 0 of the reset walk
            r_trstn   <= 1'b1;
            r_phase   <= '0;
            r_tickIdx <= '0;
            r_tck     <= 1'b0;
            r_tms     <= 1'b1;
          end else if (w_rise) begin
            r_tck   <= 1'b1;
            r_phase <= r_phase + 1'b1;
          end else if (w_tickEnd) begin
            r_tck   <= 1'b0;
            r_phase <= '0;
            case (r_state)
              ST_RSTSEQ: begin
                if (r_tickIdx == LenW'(5)) begin
                  r_tms   <= 1'b0;
                  r_state <= r_isReset ? ST_RESP : ST_IDLE;
                end else begin
                  r_tickIdx <= w_idxNext;
                  r_tms     <= (w_idxNext != LenW'(5));
                end
              end
              ST_PRE: begin
                if (w_preLast) begin
                  r_state   <= ST_SHIFT;
                  r_tickIdx <= '0;
                  r_tms     <= (r_len == '0);
                  r_tdi     <= r_data[0];
                end else begin
                  r_tickIdx <= w_idxNext;
                  r_tms     <= r_isIr && (w_idxNext == LenW'(1));
                  r_tdi     <= 1'b0;
                end
              end
              ST_SHIFT: begin
                if (r_tickIdx == r_len) begin
                  r_state   <= ST_POST;
                  r_tickIdx <= '0;
                  r_tms     <= 1'b1;
                  r_tdi     <= 1'b0;
                end else begin
                  r_tickIdx <= w_idxNext;
                  r_tms     <= (w_idxNext == r_len);
                  r_tdi     <= r_data[w_idxNext];
                end
              end
              ST_POST: begin
                r_tdi <= 1'b0;
                r_tms <= 1'b0;
                if (r_tickIdx == '0) begin
                  r_tickIdx <= w_idxNext;
                end else begin
                  r_state <= ST_RESP;
                end
              end
              default: begin
                r_state <= ST_RSTSEQ;
              end
            endcase
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
      endcase
    end
  end

  // Request fields are captured once at accept so later input changes are harmless
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_isIr    <= 1'b0;
      r_isReset <= 1'b0;
      r_len     <= '0;
      r_data    <= '0;
    end else if (w_accept) begin
      r_isIr    <= bus.req_ir_i;
      r_isReset <= bus.req_reset_i;
      r_len     <= bus.req_len_i;
      r_data    <= bus.req_data_i;
    end
  end

  // TDO capture: cleared at accept so unshifted bits read as zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rspData <= '0;
    end else if (w_accept) begin
      r_rspData <= '0;
    end else if ((r_state == ST_SHIFT) && r_trstn && w_rise) begin
      r_rspData[r_tickIdx] <= jtag_tdo_i;
    end
  end

  assign bus.req_ready_o = (r_state == ST_IDLE);
  assign bus.rsp_valid_o = (r_state == ST_RESP);
  assign bus.rsp_data_o  = r_rspData;

  assign jtag_tck_o   = r_tck;
  assign jtag_tms_o   = r_tms;
  assign jtag_tdi_o   = r_tdi;
  assign jtag_trst_no = r_trstn;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Testbench for jtag_scan_master: drives scan requests against a small
// IEEE 1149.1 TAP model (IDCODE DR, 5-bit IR) and checks responses, TMS/TDI
// sequences, tick counts and latency against expectations built from the
// scan rules.
module tb_jtag_scan_master;

  localparam int          CLKDIV = 4;
  localparam logic [31:0] IDCODE = 32'h1234_5679;
  localparam logic [4:0]  IRCAP  = 5'b00001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tck, tms, tdi, trstN, tdo;
  bit   tieHigh = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  jtag_scan_master_if #(.MaxLen(64)) bus();

  jtag_scan_master #(.ClkDiv(CLKDIV), .MaxLen(64)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .jtag_tck_o  (tck),
    .jtag_tms_o  (tms),
    .jtag_tdi_o  (tdi),
    .jtag_trst_no(trstN),
    .jtag_tdo_i  (tdo)
  );

  always #5 clk = ~clk;

  // Cycle counter: value seen at a negedge is the number of posedges so far
  always @(posedge clk) cyc <= cyc + 1;

  // TAP controller model
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_e;
  tap_e        tap   = TLR;
  logic [31:0] drSh  = '0;
  logic [4:0]  irSh  = '0;
  logic [4:0]  irReg = '0;

  function automatic tap_e tapNext(input tap_e s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PADR;
      PADR:    return m ? EX2DR : PADR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PAIR;
      PAIR:    return m ? EX2IR : PAIR;
      EX2IR:   return m ? UPIR  : SHIR;
      UPIR:    return m ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  // TAP model advances on rising TCK, TRSTn forces Test-Logic-Reset
  always @(posedge tck or negedge trstN) begin
    if (!trstN) begin
      tap   <= TLR;
      irReg <= '0;
    end else begin
      case (tap)
        CAPDR:   drSh  <= IDCODE;
        SHDR:    drSh  <= {tdi, drSh[31:1]};
        CAPIR:   irSh  <= IRCAP;
        SHIR:    irSh  <= {tdi, irSh[4:1]};
        UPIR:    irReg <= irSh;
        default: ;
      endcase
      tap <= tapNext(tap, tms);
    end
  end

  assign tdo = tieHigh ? 1'b1 : (tap == SHDR) ? drSh[0] : (tap == SHIR) ? irSh[0] : 1'b0;

  // Pin monitor: TMS/TDI as seen by the target on each rising TCK
  int           pulseCnt = 0;
  logic [127:0] tmsBits  = '0;
  logic [127:0] tdiBits  = '0;
  always @(posedge tck) begin
    if (pulseCnt < 128) begin
      tmsBits[pulseCnt] <= tms;
      tdiBits[pulseCnt] <= tdi;
    end
    pulseCnt <= pulseCnt + 1;
  end

  // Expected pin sequence of a request, built from the TAP walk it must perform
  task automatic buildSeq(input bit isRst, input bit ir, input int len, input logic [63:0] data,
                          output logic [127:0] eTms, output logic [127:0] eTdi, output int n);
    eTms = '0;
    eTdi = '0;
    n    = 0;
    if (isRst) begin
      for (int i = 0; i < 5; i++) begin
        eTms[n] = 1'b1;
        n++;
      end
      n++;
    end else begin
      eTms[n] = 1'b1;
      n++;
      if (ir) begin
        eTms[n] = 1'b1;
        n++;
      end
      n += 2;
      for (int i = 0; i <= len; i++) begin
        eTdi[n] = data[i];
        eTms[n] = (i == len);
        n++;
      end
      eTms[n] = 1'b1;
      n += 2;
    end
  endtask

  // Expected capture: register's capture value comes out first, then our own TDI bits
  function automatic logic [63:0] expRsp(input bit isRst, input bit ir, input int len,
                                         input logic [63:0] data);
    logic [63:0] r   = '0;
    logic [31:0] id  = IDCODE;
    logic [4:0]  cap = IRCAP;
    if (isRst) return '0;
    for (int i = 0; i <= len; i++) begin
      if (ir) begin
        if (i < 5) r[i] = cap[i];
        else       r[i] = data[i-5];
      end else begin
        if (i < 32) r[i] = id[i];
        else        r[i] = data[i-32];
      end
    end
    return r;
  endfunction

  task automatic waitReady();
    int n = 0;
    while (bus.req_ready_o !== 1'b1) begin
      if (n >= 4000) begin
        $display("[TB] FAIL wait_ready timeout got=%b exp=1", bus.req_ready_o);
        $fatal(1, "[TB] stopped on timeout");
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic waitRspValid();
    int n = 0;
    while (bus.rsp_valid_o !== 1'b1) begin
      if (n >= 4000) begin
        $display("[TB] FAIL wait_rsp timeout got=%b exp=1", bus.rsp_valid_o);
        $fatal(1, "[TB] stopped on timeout");
      end
      @(negedge clk);
      n++;
    end
  endtask

  // One full request/response transaction; request fields are scrambled right after accept
  task automatic runScan(input bit isRst, input bit ir, input int len, input logic [63:0] data,
                         output logic [63:0] got, output int lat);
    int e0;
    pulseCnt = 0;
    tmsBits  = '0;
    tdiBits  = '0;
    bus.req_valid_i = 1'b1;
    bus.req_reset_i = isRst;
    bus.req_ir_i    = ir;
    bus.req_len_i   = 6'(len);
    bus.req_data_i  = data;
    waitReady();
    e0 = cyc + 1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_reset_i = 1'($urandom_range(0, 1));
    bus.req_ir_i    = 1'($urandom_range(0, 1));
    bus.req_len_i   = 6'($urandom);
    bus.req_data_i  = {$urandom, $urandom};
    waitRspValid();
    lat = cyc - e0;
    got = bus.rsp_data_o;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    int rel;
    repeat (3) @(negedge clk);
    total++;
    if ({tck, tms, tdi, trstN, bus.req_ready_o, bus.rsp_valid_o} !== 6'b010000) begin
      bad++;
      $display("[TB] FAIL reset_pins got=%b exp=010000",
               {tck, tms, tdi, trstN, bus.req_ready_o, bus.rsp_valid_o});
    end
    total++;
    if (bus.rsp_data_o !== 64'h0) begin
      bad++;
      $display("[TB] FAIL reset_rsp_data got=%h exp=0", bus.rsp_data_o);
    end
    pulseCnt = 0;
    tmsBits  = '0;
    rst_n    = 1'b1;
    rel      = cyc;
    @(negedge clk);
    total++;
    if (trstN !== 1'b1) begin
      bad++;
      $display("[TB] FAIL trst_release got=%b exp=1", trstN);
    end
    waitReady();
    total++;
    if (cyc !== rel + 1 + 12 * CLKDIV) begin
      bad++;
      $display("[TB] FAIL ready_time got=%0d exp=%0d", cyc - rel - 1, 12 * CLKDIV);
    end
    total++;
    if (pulseCnt !== 6 || tmsBits[5:0] !== 6'h1F) begin
      bad++;
      $display("[TB] FAIL rstseq_tms got=%0d/%b exp=6/011111", pulseCnt, tmsBits[5:0]);
    end
    total++;
    if (tap !== RTI) begin
      bad++;
      $display("[TB] FAIL rstseq_tap got=%0d exp=%0d", tap, RTI);
    end
  endtask

  task automatic test_dr_idcode();
    logic [63:0] got;
    int lat;
    runScan(1'b0, 1'b0, 31, 64'h0, got, lat);
    total++;
    if (got !== 64'h0000_0000_1234_5679) begin
      bad++;
      $display("[TB] FAIL idcode_rsp got=%h exp=0000000012345679", got);
    end
    total++;
    if (pulseCnt !== 37) begin
      bad++;
      $display("[TB] FAIL idcode_pulses got=%0d exp=37", pulseCnt);
    end
    total++;
    if (lat !== 37 * 2 * CLKDIV) begin
      bad++;
      $display("[TB] FAIL idcode_latency got=%0d exp=%0d", lat, 37 * 2 * CLKDIV);
    end
    total++;
    if (tap !== RTI) begin
      bad++;
      $display("[TB] FAIL idcode_tap got=%0d exp=%0d", tap, RTI);
    end
  endtask

  task automatic test_ir_scan();
    logic [63:0] got;
    int lat;
    runScan(1'b0, 1'b1, 4, 64'h11, got, lat);
    total++;
    if (pulseCnt !== 11 || tmsBits[10:0] !== 11'h303) begin
      bad++;
      $display("[TB] FAIL ir_tms got=%0d/%b exp=11/01100000011", pulseCnt, tmsBits[10:0]);
    end
    total++;
    if (tdiBits[8:4] !== 5'b10001) begin
      bad++;
      $display("[TB] FAIL ir_tdi got=%b exp=10001", tdiBits[8:4]);
    end
    total++;
    if (irReg !== 5'h11 || tap !== RTI) begin
      bad++;
      $display("[TB] FAIL ir_model got=%h/%0d exp=11/%0d", irReg, tap, RTI);
    end
    total++;
    if (got !== 64'h1) begin
      bad++;
      $display("[TB] FAIL ir_rsp got=%h exp=1", got);
    end
    total++;
    if (lat !== 11 * 2 * CLKDIV) begin
      bad++;
      $display("[TB] FAIL ir_latency got=%0d exp=%0d", lat, 11 * 2 * CLKDIV);
    end
  endtask

  task automatic test_len_extremes();
    logic [63:0]  got;
    logic [127:0] eTms, eTdi;
    int lat, n;
    tieHigh = 1'b1;
    buildSeq(1'b0, 1'b0, 63, 64'h0, eTms, eTdi, n);
    runScan(1'b0, 1'b0, 63, {$urandom, $urandom}, got, lat);
    total++;
    if (got !== {64{1'b1}}) begin
      bad++;
      $display("[TB] FAIL len64_rsp got=%h exp=ffffffffffffffff", got);
    end
    total++;
    if (pulseCnt !== n || lat !== n * 2 * CLKDIV) begin
      bad++;
      $display("[TB] FAIL len64_ticks got=%0d/%0d exp=%0d/%0d", pulseCnt, lat, n, n * 2 * CLKDIV);
    end
    runScan(1'b0, 1'b0, 0, 64'h1, got, lat);
    total++;
    if (pulseCnt !== 6 || tmsBits[5:0] !== 6'h19) begin
      bad++;
      $display("[TB] FAIL len1_tms got=%0d/%b exp=6/011001", pulseCnt, tmsBits[5:0]);
    end
    total++;
    if (got !== 64'h1) begin
      bad++;
      $display("[TB] FAIL len1_rsp got=%h exp=1", got);
    end
    tieHigh = 1'b0;
  endtask

  task automatic test_random_scans();
    logic [63:0]  got, data, exp;
    logic [127:0] eTms, eTdi;
    int lat, n, len, kind;
    bit isRst, ir;
    for (int it = 0; it < 12; it++) begin
      kind  = $urandom_range(0, 4);
      isRst = (kind == 0);
      ir    = (kind == 1);
      len   = $urandom_range(0, 63);
      data  = {$urandom, $urandom};
      buildSeq(isRst, ir, len, data, eTms, eTdi, n);
      exp = expRsp(isRst, ir, len, data);
      runScan(isRst, ir, len, data, got, lat);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL rand_rsp it=%0d kind=%0d len=%0d got=%h exp=%h", it, kind, len, got, exp);
      end
      total++;
      if (pulseCnt !== n || tmsBits !== eTms) begin
        bad++;
        $display("[TB] FAIL rand_tms it=%0d got=%0d/%h exp=%0d/%h", it, pulseCnt, tmsBits, n, eTms);
      end
      total++;
      if (tdiBits !== eTdi) begin
        bad++;
        $display("[TB] FAIL rand_tdi it=%0d got=%h exp=%h", it, tdiBits, eTdi);
      end
      total++;
      if (lat !== n * 2 * CLKDIV) begin
        bad++;
        $display("[TB] FAIL rand_latency it=%0d got=%0d exp=%0d", it, lat, n * 2 * CLKDIV);
      end
      total++;
      if (tap !== RTI) begin
        bad++;
        $display("[TB] FAIL rand_tap it=%0d got=%0d exp=%0d", it, tap, RTI);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0]  d1, d2, snap, got, exp;
    logic [127:0] eTms, eTdi;
    int e0, lat, n;
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    bus.req_valid_i = 1'b1;
    bus.req_reset_i = 1'b0;
    bus.req_ir_i    = 1'b0;
    bus.req_len_i   = 6'd15;
    bus.req_data_i  = d1;
    waitReady();
    @(negedge clk);
    bus.req_ir_i   = 1'b1;
    bus.req_len_i  = 6'd7;
    bus.req_data_i = d2;
    waitRspValid();
    snap = bus.rsp_data_o;
    exp  = expRsp(1'b0, 1'b0, 15, d1);
    total++;
    if (snap !== exp) begin
      bad++;
      $display("[TB] FAIL bp_first_rsp got=%h exp=%h", snap, exp);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (bus.rsp_data_o !== snap || bus.req_ready_o !== 1'b0 || bus.rsp_valid_o !== 1'b1) begin
        bad++;
        $display("[TB] FAIL bp_hold cyc=%0d got=%h/%b/%b exp=%h/0/1", i, bus.rsp_data_o,
                 bus.req_ready_o, bus.rsp_valid_o, snap);
      end
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    total++;
    if (bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_after_hs got=%b/%b exp=1/0", bus.req_ready_o, bus.rsp_valid_o);
    end
    pulseCnt = 0;
    tmsBits  = '0;
    tdiBits  = '0;
    e0 = cyc + 1;
    @(negedge clk);
    total++;
    if (bus.req_ready_o !== 1'b0 || tms !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_second_accept got=%b/%b exp=0/1", bus.req_ready_o, tms);
    end
    bus.req_valid_i = 1'b0;
    waitRspValid();
    lat = cyc - e0;
    got = bus.rsp_data_o;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    buildSeq(1'b0, 1'b1, 7, d2, eTms, eTdi, n);
    exp = expRsp(1'b0, 1'b1, 7, d2);
    total++;
    if (got !== exp || lat !== n * 2 * CLKDIV) begin
      bad++;
      $display("[TB] FAIL bp_second_rsp got=%h/%0d exp=%h/%0d", got, lat, exp, n * 2 * CLKDIV);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [63:0] got;
    int rel, lat;
    bus.req_valid_i = 1'b1;
    bus.req_reset_i = 1'b0;
    bus.req_ir_i    = 1'b0;
    bus.req_len_i   = 6'd40;
    bus.req_data_i  = {$urandom, $urandom};
    waitReady();
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    repeat (2 * CLKDIV * 6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({tck, tms, tdi, trstN, bus.req_ready_o, bus.rsp_valid_o} !== 6'b010000 ||
        bus.rsp_data_o !== 64'h0) begin
      bad++;
      $display("[TB] FAIL midrst_pins got=%b/%h exp=010000/0",
               {tck, tms, tdi, trstN, bus.req_ready_o, bus.rsp_valid_o}, bus.rsp_data_o);
    end
    total++;
    if (tap !== TLR) begin
      bad++;
      $display("[TB] FAIL midrst_tap got=%0d exp=%0d", tap, TLR);
    end
    @(negedge clk);
    pulseCnt = 0;
    tmsBits  = '0;
    rst_n    = 1'b1;
    rel      = cyc;
    @(negedge clk);
    waitReady();
    total++;
    if (cyc !== rel + 1 + 12 * CLKDIV || pulseCnt !== 6 || tmsBits[5:0] !== 6'h1F) begin
      bad++;
      $display("[TB] FAIL midrst_rstseq got=%0d/%0d/%b exp=%0d/6/011111", cyc - rel - 1,
               pulseCnt, tmsBits[5:0], 12 * CLKDIV);
    end
    total++;
    if (tap !== RTI || bus.rsp_valid_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_after got=%0d/%b exp=%0d/0", tap, bus.rsp_valid_o, RTI);
    end
    runScan(1'b0, 1'b0, 31, 64'h0, got, lat);
    total++;
    if (got !== 64'h0000_0000_1234_5679) begin
      bad++;
      $display("[TB] FAIL midrst_rescan got=%h exp=0000000012345679", got);
    end
  endtask

  task automatic test_reset_request();
    logic [63:0] got;
    int lat;
    runScan(1'b1, 1'b1, 20, {$urandom, $urandom}, got, lat);
    total++;
    if (got !== 64'h0 || lat !== 6 * 2 * CLKDIV) begin
      bad++;
      $display("[TB] FAIL rstreq_rsp got=%h/%0d exp=0/%0d", got, lat, 6 * 2 * CLKDIV);
    end
    total++;
    if (pulseCnt !== 6 || tmsBits[5:0] !== 6'h1F || tap !== RTI) begin
      bad++;
      $display("[TB] FAIL rstreq_tms got=%0d/%b/%0d exp=6/011111/%0d", pulseCnt, tmsBits[5:0],
               tap, RTI);
    end
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_reset_i = 1'b0;
    bus.req_ir_i    = 1'b0;
    bus.req_len_i   = '0;
    bus.req_data_i  = '0;
    bus.rsp_ready_i = 1'b0;
    $display("[TB] starting jtag_scan_master bench");
    test_reset();
    test_dr_idcode();
    test_ir_scan();
    test_len_extremes();
    test_reset_request();
    test_random_scans();
    test_back_to_back();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
